// File: rtl/string_stream_engine.sv
// Byte-string engine: loads a string from a valid/ready stream, then runs
// len/getc/substr/toupper/tolower/clear commands and streams the results.
module string_stream_engine #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned CNT_W   = $clog2(MAX_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             in_last,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_arg0,
  input  logic [31:0]      cmd_arg1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic             out_null,
  output logic [CNT_W-1:0] str_len,
  output logic             overflow
);

  localparam int unsigned IDX_W = $clog2(MAX_LEN);

  localparam logic [2:0] OP_LEN     = 3'd0;
  localparam logic [2:0] OP_GETC    = 3'd1;
  localparam logic [2:0] OP_SUBSTR  = 3'd2;
  localparam logic [2:0] OP_TOUPPER = 3'd3;
  localparam logic [2:0] OP_TOLOWER = 3'd4;
  localparam logic [2:0] OP_CLEAR   = 3'd5;

  typedef enum logic [1:0] {S_LOAD, S_READY, S_STREAM} state_t;

  state_t           r_state, w_state_n;
  logic [7:0]       r_buf [MAX_LEN];
  logic [CNT_W-1:0] r_len, w_len_n;
  logic             r_ovf, w_ovf_n;
  logic [2:0]       r_op, w_op_n;
  logic [IDX_W-1:0] r_idx, w_idx_n;
  logic [IDX_W-1:0] r_end, w_end_n;
  logic             r_out_valid, w_out_valid_n;
  logic [7:0]       r_out_byte, w_out_byte_n;
  logic             r_out_last, w_out_last_n;
  logic             r_out_null, w_out_null_n;
  logic             r_in_ready, w_in_ready_n;
  logic             r_cmd_ready, w_cmd_ready_n;
  logic             w_wr_en;

  logic signed [31:0] w_a0, w_a1, w_len_s;
  logic               w_arg0_ok, w_sub_ok;
  logic [IDX_W-1:0]   w_a0_idx, w_a1_idx;

  // Signed 32-bit argument range checks; negatives never wrap into range
  assign w_a0      = $signed(cmd_arg0);
  assign w_a1      = $signed(cmd_arg1);
  assign w_len_s   = $signed(32'(r_len));
  assign w_arg0_ok = (w_a0 >= 32'sd0) && (w_a0 < w_len_s);
  assign w_sub_ok  = w_arg0_ok && (w_a1 >= w_a0) && (w_a1 < w_len_s);
  assign w_a0_idx  = cmd_arg0[IDX_W-1:0];
  assign w_a1_idx  = cmd_arg1[IDX_W-1:0];

  function automatic logic [7:0] f_xform(input logic [2:0] op, input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (op == OP_TOUPPER && b >= 8'h61 && b <= 8'h7A) r = b - 8'h20;
    if (op == OP_TOLOWER && b >= 8'h41 && b <= 8'h5A) r = b + 8'h20;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_len       <= '0;
      r_ovf       <= 1'b0;
      r_op        <= '0;
      r_idx       <= '0;
      r_end       <= '0;
      r_out_valid <= 1'b0;
      r_out_byte  <= '0;
      r_out_last  <= 1'b0;
      r_out_null  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_cmd_ready <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_len       <= w_len_n;
      r_ovf       <= w_ovf_n;
      r_op        <= w_op_n;
      r_idx       <= w_idx_n;
      r_end       <= w_end_n;
      r_out_valid <= w_out_valid_n;
      r_out_byte  <= w_out_byte_n;
      r_out_last  <= w_out_last_n;
      r_out_null  <= w_out_null_n;
      r_in_ready  <= w_in_ready_n;
      r_cmd_ready <= w_cmd_ready_n;
    end
  end

  // String storage has no reset; contents are meaningless until loaded
  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[r_len[IDX_W-1:0]] <= in_byte;
  end

  always_comb begin
    w_state_n     = r_state;
    w_len_n       = r_len;
    w_ovf_n       = r_ovf;
    w_op_n        = r_op;
    w_idx_n       = r_idx;
    w_end_n       = r_end;
    w_out_valid_n = r_out_valid;
    w_out_byte_n  = r_out_byte;
    w_out_last_n  = r_out_last;
    w_out_null_n  = r_out_null;
    w_wr_en       = 1'b0;

    case (r_state)
      S_LOAD: begin
        if (in_valid) begin
          if (r_len == CNT_W'(MAX_LEN)) begin
            w_ovf_n = 1'b1;
          end else begin
            w_wr_en = 1'b1;
            w_len_n = r_len + CNT_W'(1);
          end
          if (in_last) w_state_n = S_READY;
        end
      end

      S_READY: begin
        if (cmd_valid) begin
          // Present the first result beat directly on the accepting edge
          w_op_n        = cmd_op;
          w_state_n     = S_STREAM;
          w_out_valid_n = 1'b1;
          w_out_last_n  = 1'b1;
          w_out_null_n  = 1'b0;
          w_out_byte_n  = 8'h00;
          case (cmd_op)
            OP_LEN: w_out_byte_n = 8'(r_len);
            OP_GETC: begin
              if (w_arg0_ok) w_out_byte_n = r_buf[w_a0_idx];
              else           w_out_null_n = 1'b1;
            end
            OP_SUBSTR: begin
              if (w_sub_ok) begin
                w_idx_n      = w_a0_idx;
                w_end_n      = w_a1_idx;
                w_out_byte_n = r_buf[w_a0_idx];
                w_out_last_n = (w_a0_idx == w_a1_idx);
              end else begin
                w_out_null_n = 1'b1;
              end
            end
            OP_TOUPPER, OP_TOLOWER: begin
              if (r_len != '0) begin
                w_idx_n      = '0;
                w_end_n      = IDX_W'(r_len - CNT_W'(1));
                w_out_byte_n = f_xform(cmd_op, r_buf[0]);
                w_out_last_n = (r_len == CNT_W'(1));
              end else begin
                w_out_null_n = 1'b1;
              end
            end
            OP_CLEAR: begin
              w_state_n     = S_LOAD;
              w_out_valid_n = 1'b0;
              w_out_last_n  = 1'b0;
              w_len_n       = '0;
              w_ovf_n       = 1'b0;
            end
            default: w_out_null_n = 1'b1;
          endcase
        end
      end

      S_STREAM: begin
        if (out_ready) begin
          if (r_out_last) begin
            w_state_n     = S_READY;
            w_out_valid_n = 1'b0;
            w_out_byte_n  = 8'h00;
            w_out_last_n  = 1'b0;
            w_out_null_n  = 1'b0;
          end else begin
            w_idx_n      = r_idx + IDX_W'(1);
            w_out_byte_n = f_xform(r_op, r_buf[w_idx_n]);
            w_out_last_n = (w_idx_n == r_end);
          end
        end
      end

      default: w_state_n = S_LOAD;
    endcase

    w_in_ready_n  = (w_state_n == S_LOAD);
    w_cmd_ready_n = (w_state_n == S_READY);
  end

  assign in_ready  = r_in_ready;
  assign cmd_ready = r_cmd_ready;
  assign out_valid = r_out_valid;
  assign out_byte  = r_out_byte;
  assign out_last  = r_out_last;
  assign out_null  = r_out_null;
  assign str_len   = r_len;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_string_stream_engine.sv
// Directed bench for string_stream_engine: load, each method, stalls,
// overflow saturation, clear and asynchronous reset mid-stream.
module tb_string_stream_engine;

  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN) + 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_byte;
  logic             in_last;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [31:0]      cmd_arg0;
  logic [31:0]      cmd_arg1;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_byte;
  logic             out_last;
  logic             out_null;
  logic [CNT_W-1:0] str_len;
  logic             overflow;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_b [0:7];

  string_stream_engine #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_last(in_last),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_arg0(cmd_arg0), .cmd_arg1(cmd_arg1),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .out_null(out_null),
    .str_len(str_len), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    in_valid = 1'b1; in_byte = b; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [31:0] a0, input logic [31:0] a1);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg0 = a0; cmd_arg1 = a1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Consume n beats against exp_b; optionally stall one cycle per beat
  task automatic get_stream(input string tag, input int n, input logic nul, input bit stall);
    out_ready = !stall;
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_byte"},  32'(out_byte),  32'(exp_b[i]));
      check({tag, "_last"},  32'(out_last),  32'(i == n - 1));
      check({tag, "_null"},  32'(out_null),  32'(nul));
      if (stall) begin
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_byte"},  32'(out_byte),  32'(exp_b[i]));
        check({tag, "_hold_last"},  32'(out_last),  32'(i == n - 1));
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (stall) out_ready = 1'b0;
    end
    out_ready = 1'b0;
    check({tag, "_end_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_end_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_byte = '0; in_last = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_arg0 = '0; cmd_arg1 = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_str_len",   32'(str_len),   32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_out_byte",  32'(out_byte),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // "hello" then TOUPPER at full rate
    send_byte(8'h68, 1'b0); send_byte(8'h65, 1'b0); send_byte(8'h6C, 1'b0);
    send_byte(8'h6C, 1'b0); send_byte(8'h6F, 1'b1);
    check("hello_len", 32'(str_len), 32'd5);
    check("hello_in_ready", 32'(in_ready), 32'd0);
    send_cmd(3'd3, 32'd0, 32'd0);
    check("upper_latency", 32'(out_valid), 32'd1);
    exp_b[0] = 8'h48; exp_b[1] = 8'h45; exp_b[2] = 8'h4C; exp_b[3] = 8'h4C; exp_b[4] = 8'h4F;
    get_stream("upper", 5, 1'b0, 1'b0);

    // SUBSTR 1..3 with stalls
    send_cmd(3'd2, 32'd1, 32'd3);
    exp_b[0] = 8'h65; exp_b[1] = 8'h6C; exp_b[2] = 8'h6C;
    get_stream("substr", 3, 1'b0, 1'b1);

    // GETC out of range both sides, then in range
    exp_b[0] = 8'h00;
    send_cmd(3'd1, 32'hFFFF_FFFF, 32'd0);
    get_stream("getc_neg", 1, 1'b1, 1'b0);
    send_cmd(3'd1, 32'd5, 32'd0);
    get_stream("getc_5", 1, 1'b1, 1'b0);
    exp_b[0] = 8'h6F;
    send_cmd(3'd1, 32'd4, 32'd0);
    get_stream("getc_4", 1, 1'b0, 1'b0);
    exp_b[0] = 8'h05;
    send_cmd(3'd0, 32'd0, 32'd0);
    get_stream("len5", 1, 1'b0, 1'b0);

    // CLEAR, then overflow with 40 bytes
    send_cmd(3'd5, 32'd0, 32'd0);
    check("clr1_len", 32'(str_len), 32'd0);
    check("clr1_in_ready", 32'(in_ready), 32'd1);
    check("clr1_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 40; i++) send_byte(8'(i + 1), 1'(i == 39));
    check("ovf_len", 32'(str_len), 32'd32);
    check("ovf_flag", 32'(overflow), 32'd1);
    exp_b[0] = 8'h20;
    send_cmd(3'd0, 32'd0, 32'd0);
    get_stream("len32", 1, 1'b0, 1'b0);
    exp_b[0] = 8'h20;
    send_cmd(3'd1, 32'd31, 32'd0);
    get_stream("getc_31", 1, 1'b0, 1'b0);
    send_cmd(3'd5, 32'd0, 32'd0);
    check("clr2_len", 32'(str_len), 32'd0);
    check("clr2_ovf", 32'(overflow), 32'd0);
    check("clr2_in_ready", 32'(in_ready), 32'd1);

    // "AbZ!" TOLOWER, reversed SUBSTR, reserved op
    send_byte(8'h41, 1'b0); send_byte(8'h62, 1'b0); send_byte(8'h5A, 1'b0); send_byte(8'h21, 1'b1);
    check("abz_len", 32'(str_len), 32'd4);
    send_cmd(3'd4, 32'd0, 32'd0);
    exp_b[0] = 8'h61; exp_b[1] = 8'h62; exp_b[2] = 8'h7A; exp_b[3] = 8'h21;
    get_stream("lower", 4, 1'b0, 1'b0);
    exp_b[0] = 8'h00;
    send_cmd(3'd2, 32'd2, 32'd1);
    get_stream("substr_rev", 1, 1'b1, 1'b0);
    send_cmd(3'd6, 32'd0, 32'd0);
    get_stream("reserved", 1, 1'b1, 1'b0);
    send_cmd(3'd2, 32'd3, 32'd3);
    exp_b[0] = 8'h21;
    get_stream("substr_one", 1, 1'b0, 1'b0);

    // Async reset during a stalled TOUPPER stream
    send_cmd(3'd3, 32'd0, 32'd0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_byte", 32'(out_byte), 32'h41);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_len", 32'(str_len), 32'd0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("post_rst_valid", 32'(out_valid), 32'd0);
    end
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
